lif_membrane_update: RTL and testbench

- Leaky integrate-and-fire update stage that drives the membrane potential register (21-bit signed Q12.9, 9 fractional bits, units of mV).
- On each accepted timestep strobe it reads the stored potential and the synaptic current, applies leak and input, and compares against threshold.
- It then drives the next potential and a set/reset pulse back into the register, emits a spike, and enforces a refractory period.

---
 rtl/lif_membrane_update.sv | 140 ++++++++++++++
 tb/tb_lif_membrane_update.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_membrane_update.sv
// ============================================================================
// Module      : lif_membrane_update
// Description : Leaky integrate-and-fire update stage. It leaks, integrates and
//               thresholds a Q12.9 membrane potential, then drives the
//               potential register and enforces a refractory period.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lif_membrane_update #(
    parameter int WIDTH      = 21,
    parameter int V_REST     = -35840,
    parameter int V_TH       = -28160,
    parameter int LEAK_SHIFT = 4,
    parameter int REF_STEPS  = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    step,
    input  logic signed [WIDTH-1:0] v_in,
    input  logic signed [WIDTH-1:0] i_syn,
    output logic signed [WIDTH-1:0] v_next,
    output logic                    set_v,
    output logic                    spike,
    output logic                    busy,
    output logic                    refractory
);

    localparam logic signed [WIDTH-1:0] c_v_rest   = WIDTH'(V_REST);
    localparam logic signed [WIDTH-1:0] c_v_th     = WIDTH'(V_TH);
    localparam logic        [7:0]       c_ref_load = 8'(REF_STEPS);
    localparam logic signed [WIDTH+1:0] c_sum_max  = (WIDTH+2)'(2**(WIDTH-1) - 1);
    localparam logic signed [WIDTH+1:0] c_sum_min  = ~c_sum_max;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CALC    = 3'd1,
        S_WRITE   = 3'd2,
        S_SETTLE  = 3'd3,
        S_REFRACT = 3'd4
    } state_t;

    state_t                  r_state;
    logic signed [WIDTH-1:0] r_v;
    logic signed [WIDTH-1:0] r_i;
    logic signed [WIDTH:0]   r_leak;
    logic signed [WIDTH-1:0] r_sat;
    logic        [7:0]       r_ref_cnt;

    logic signed [WIDTH:0]   w_diff;
    logic signed [WIDTH:0]   w_leak;
    logic signed [WIDTH+1:0] w_sum;
    logic signed [WIDTH-1:0] w_sat;

    // One extra bit keeps v_in - V_REST exact across the full input range.
    assign w_diff = {v_in[WIDTH-1], v_in} - {c_v_rest[WIDTH-1], c_v_rest};
    assign w_leak = w_diff >>> LEAK_SHIFT;
    assign w_sum  = {{2{r_v[WIDTH-1]}}, r_v}
                  + {{2{r_i[WIDTH-1]}}, r_i}
                  - {r_leak[WIDTH], r_leak};

    always_comb begin
        w_sat = w_sum[WIDTH-1:0];
        if (w_sum > c_sum_max) begin
            w_sat = c_sum_max[WIDTH-1:0];
        end else if (w_sum < c_sum_min) begin
            w_sat = c_sum_min[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_v        <= '0;
            r_i        <= '0;
            r_leak     <= '0;
            r_sat      <= '0;
            r_ref_cnt  <= '0;
            v_next     <= c_v_rest;
            set_v      <= 1'b1;
            spike      <= 1'b0;
            busy       <= 1'b0;
            refractory <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Also releases the set request left over from reset.
                    set_v <= 1'b0;
                    if (step) begin
                        r_v     <= v_in;
                        r_i     <= i_syn;
                        r_leak  <= w_leak;
                        busy    <= 1'b1;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_sat   <= w_sat;
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    if (r_sat >= c_v_th) begin
                        v_next     <= c_v_rest;
                        set_v      <= 1'b1;
                        spike      <= 1'b1;
                        r_ref_cnt  <= c_ref_load;
                        refractory <= 1'b1;
                    end else begin
                        v_next <= r_sat;
                        set_v  <= 1'b0;
                        spike  <= 1'b0;
                    end
                    r_state <= S_SETTLE;
                end
                S_SETTLE: begin
                    spike   <= 1'b0;
                    set_v   <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= (r_ref_cnt != 8'd0) ? S_REFRACT : S_IDLE;
                end
                S_REFRACT: begin
                    // Steps are consumed here without integrating i_syn.
                    if (step) begin
                        r_ref_cnt <= r_ref_cnt - 8'd1;
                        if (r_ref_cnt == 8'd1) begin
                            refractory <= 1'b0;
                            r_state    <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lif_membrane_update.sv
// ============================================================================
// Module      : tb_lif_membrane_update
// Description : Self-checking bench for lif_membrane_update with a timeline
//               reference model, directed cases and randomized stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lif_membrane_update;

    localparam int W      = 21;
    localparam int V_REST = -35840;
    localparam int V_TH   = -28160;
    localparam int LS     = 4;
    localparam int REF    = 5;
    localparam int MAXV   = 1048575;
    localparam int MINV   = -1048576;

    logic                clk = 1'b0;
    logic                rst;
    logic                step;
    logic signed [W-1:0] v_in;
    logic signed [W-1:0] i_syn;
    logic signed [W-1:0] v_next;
    logic                set_v;
    logic                spike;
    logic                busy;
    logic                refractory;

    int n_cmp = 0;
    int n_bad = 0;

    lif_membrane_update #(
        .WIDTH      (W),
        .V_REST     (V_REST),
        .V_TH       (V_TH),
        .LEAK_SHIFT (LS),
        .REF_STEPS  (REF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .step       (step),
        .v_in       (v_in),
        .i_syn      (i_syn),
        .v_next     (v_next),
        .set_v      (set_v),
        .spike      (spike),
        .busy       (busy),
        .refractory (refractory)
    );

    always #5 clk = ~clk;

    // Reference: leak with floor division, full-precision sum, then clamp.
    function automatic int model_sum(input int v, input int i);
        int d;
        int leak;
        int s;
        d = v - V_REST;
        if (d >= 0) leak = d / (1 << LS);
        else        leak = -((-d + (1 << LS) - 1) / (1 << LS));
        s = v + i - leak;
        if (s > MAXV) s = MAXV;
        if (s < MINV) s = MINV;
        return s;
    endfunction

    // Model: an update accepted at edge A publishes at A+2, is busy for
    // edges A..A+2, and the next step can be taken from A+4 onwards.
    int m_edge  = 0;
    int m_acc   = -1000;
    int m_res   = 0;
    bit m_fire  = 1'b0;
    int m_refr  = 0;
    int m_vnext = V_REST;
    bit m_set   = 1'b1;
    bit m_spike = 1'b0;
    bit m_busy  = 1'b0;

    task automatic model_tick();
        if (rst) begin
            m_acc   = -1000;
            m_refr  = 0;
            m_vnext = V_REST;
            m_set   = 1'b1;
            m_spike = 1'b0;
            m_busy  = 1'b0;
        end else begin
            m_edge++;
            m_set   = 1'b0;
            m_spike = 1'b0;
            if (m_edge == m_acc + 2) begin
                if (m_fire) begin
                    m_vnext = V_REST;
                    m_set   = 1'b1;
                    m_spike = 1'b1;
                    m_refr  = REF;
                end else begin
                    m_vnext = m_res;
                end
            end
            if (step && m_edge >= m_acc + 4) begin
                if (m_refr > 0) begin
                    m_refr--;
                end else begin
                    m_acc  = m_edge;
                    m_res  = model_sum(int'(v_in), int'(i_syn));
                    m_fire = (m_res >= V_TH);
                end
            end
            m_busy = (m_edge - m_acc) <= 2;
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_tick();
    end

    initial forever begin
        @(negedge clk);
        n_cmp++;
        if (int'(v_next) != m_vnext || set_v != m_set || spike != m_spike ||
            busy != m_busy || refractory != (m_refr > 0)) begin
            n_bad++;
            $display("FAIL cycle t=%0t got v_next=%0d set_v=%b spike=%b busy=%b refr=%b, need v_next=%0d set_v=%b spike=%b busy=%b refr=%b",
                     $time, v_next, set_v, spike, busy, refractory,
                     m_vnext, m_set, m_spike, m_busy, (m_refr > 0));
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Leaves the bench just after edge T+2 of the accepted step.
    task automatic do_step(input int v, input int i);
        @(negedge clk);
        v_in  = W'(v);
        i_syn = W'(i);
        step  = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int changes;
        int prev;
        int v;
        int i;

        rst   = 1'b1;
        step  = 1'b0;
        v_in  = W'(V_REST);
        i_syn = '0;
        repeat (2) @(negedge clk);
        check("reset v_next", int'(v_next), V_REST);
        check("reset set_v", int'(set_v), 1);
        check("reset busy", int'(busy), 0);
        rst = 1'b0;
        @(negedge clk);
        check("set_v after release", int'(set_v), 0);

        // Pin the reference arithmetic with hand-computed values.
        check("model rest", model_sum(-35840, 0), -35840);
        check("model leak", model_sum(-30720, 0), -31040);
        check("model fire", model_sum(-30720, 5120), -25920);
        check("model sat lo", model_sum(-1048576, -1048576), -1048576);
        check("model sat hi", model_sum(1048000, 1048575), 1048575);
        check("model floor", model_sum(-33000, 100), -33077);

        do_step(-35840, 0);
        check("rest v_next", int'(v_next), -35840);
        check("rest spike", int'(spike), 0);

        do_step(-30720, 0);
        check("leak v_next", int'(v_next), -31040);
        check("leak spike", int'(spike), 0);

        do_step(-30720, 5120);
        check("fire v_next", int'(v_next), -35840);
        check("fire spike", int'(spike), 1);
        check("fire set_v", int'(set_v), 1);
        @(negedge clk);
        check("fire spike width", int'(spike), 0);
        check("fire refractory", int'(refractory), 1);
        for (int k = 0; k < REF; k++) begin
            do_step(-35840, 20000);
            check("refract v_next", int'(v_next), -35840);
            check("refract spike", int'(spike), 0);
            check("refract flag", int'(refractory), (k < REF - 1) ? 1 : 0);
        end
        do_step(-35840, 1000);
        check("post refract v_next", int'(v_next), -34840);

        do_step(-1048576, -1048576);
        check("sat lo v_next", int'(v_next), -1048576);
        check("sat lo spike", int'(spike), 0);

        do_step(1048000, 1048575);
        check("sat hi spike", int'(spike), 1);
        for (int k = 0; k < REF; k++) do_step(-35840, 0);

        // Three back-to-back strobes yield a single update.
        @(negedge clk);
        prev    = int'(v_next);
        changes = 0;
        v_in    = W'(-33000);
        i_syn   = W'(100);
        step    = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 2) step = 1'b0;
            if (int'(v_next) != prev) changes++;
            prev = int'(v_next);
        end
        check("busy drop changes", changes, 1);
        check("busy drop v_next", int'(v_next), -33077);

        // Asynchronous reset while the update sits in CALC.
        @(negedge clk);
        v_in  = W'(-30720);
        i_syn = '0;
        step  = 1'b1;
        @(negedge clk);
        step = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("async rst v_next", int'(v_next), V_REST);
        check("async rst set_v", int'(set_v), 1);
        check("async rst busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst release set_v", int'(set_v), 0);
        check("rst release spike", int'(spike), 0);
        do_step(-30720, 0);
        check("after rst v_next", int'(v_next), -31040);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            step = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0:       v = int'($urandom_range(0, 2097151)) - 1048576;
                1:       v = MAXV - int'($urandom_range(0, 2000));
                2:       v = MINV + int'($urandom_range(0, 2000));
                default: v = -40000 + int'($urandom_range(0, 20000));
            endcase
            case ($urandom_range(0, 5))
                0:       i = int'($urandom_range(0, 2097151)) - 1048576;
                default: i = -6000 + int'($urandom_range(0, 18000));
            endcase
            v_in  = W'(v);
            i_syn = W'(i);
            if (c % 701 == 350) begin
                #2 rst = 1'b1;
                #2 rst = 1'b0;
            end
        end
        step = 1'b0;
        repeat (8) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
